dcfifo_cont: RTL and testbench

Single-clock streaming FIFO with a read-start threshold. It buffers a flagged data stream (one valid bit embedded in each word). It begins emitting only once `RD_THR` words are queued, then streams one word per cycle until it runs empty. It sits between a bursty producer and a consumer that needs gap-free bursts after an initial pre-fill.

---
 rtl/dcfifo_cont.sv | 95 +++++++++
 tb/tb_dcfifo_cont.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dcfifo_cont.sv
// Single-clock streaming FIFO that starts emitting once RD_THR words are queued,
// then streams one word per cycle until empty. The valid flag rides inside the word.
`timescale 1ns/1ps
module dcfifo_cont #(
  parameter int DW           = 27,
  parameter int EN_BIT       = 25,
  parameter int RD_THR       = 11,
  parameter int FIFO_LEN_LOG = 5
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          CLR,
  input  logic          EN,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dot
);

  localparam int DEPTH = 1 << FIFO_LEN_LOG;
  localparam int CW    = FIFO_LEN_LOG + 1;
  localparam logic [CW-1:0] THR  = CW'(RD_THR);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {WAIT, STREAM} state_t;

  state_t                  state, state_nxt;
  logic [DW-2:0]           mem [DEPTH];
  logic [FIFO_LEN_LOG-1:0] wptr, rptr;
  logic [CW-1:0]           count;
  logic                    rd, wr;
  logic [DW-2:0]           pay_in, pay_out;
  logic [DW-1:0]           rd_word;

  assign pay_out = mem[rptr];

  // Strip the flag bit on the way in and put it back on the way out.
  generate
    if (EN_BIT == 0) begin : g_lsb
      assign pay_in  = din[DW-1:1];
      assign rd_word = {pay_out, 1'b1};
    end else if (EN_BIT == DW-1) begin : g_msb
      assign pay_in  = din[DW-2:0];
      assign rd_word = {1'b1, pay_out};
    end else begin : g_mid
      assign pay_in  = {din[DW-1:EN_BIT+1], din[EN_BIT-1:0]};
      assign rd_word = {pay_out[DW-2:EN_BIT], 1'b1, pay_out[EN_BIT-1:0]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    case (state)
      WAIT: begin
        rd = EN && (count >= THR);
        if (rd) state_nxt = STREAM;
      end
      STREAM: begin
        rd = EN && (count != '0);
        if (EN && (count == '0)) state_nxt = WAIT;
      end
      default: state_nxt = WAIT;
    endcase
  end

  // A full FIFO still accepts a word when a read frees the slot on the same edge.
  assign wr = EN && din[EN_BIT] && ((count < FULL) || rd);

  always_ff @(posedge CLK) begin
    if (wr && !CLR && !RST_X) mem[wptr] <= pay_in;
  end

  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) begin
      state <= WAIT;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dot   <= '0;
    end else if (CLR) begin
      state <= WAIT;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dot   <= '0;
    end else begin
      state <= state_nxt;
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      if (wr && !rd)      count <= count + 1'b1;
      else if (rd && !wr) count <= count - 1'b1;
      dot <= rd ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_dcfifo_cont.sv
// Scoreboard bench for dcfifo_cont: stimulus pushes expected payloads, a negedge
// monitor pops and compares every valid output word; timing is checked inline.
`timescale 1ns/1ps
module tb_dcfifo_cont;
  localparam int DW = 27;
  localparam int EB = 25;

  logic          CLK = 1'b0;
  logic          RST_X = 1'b0;
  logic          CLR = 1'b0;
  logic          EN = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dot;

  int            checks = 0;
  int            errors = 0;
  logic [DW-2:0] exp_q[$];

  dcfifo_cont #(.DW(27), .EN_BIT(25), .RD_THR(11), .FIFO_LEN_LOG(5)) dut (
    .CLK(CLK), .RST_X(RST_X), .CLR(CLR), .EN(EN), .din(din), .dot(dot)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] mk(input logic [DW-2:0] p, input logic f);
    return {p[25], f, p[24:0]};
  endfunction

  function automatic logic [DW-2:0] pay(input logic [DW-1:0] w);
    return {w[26], w[24:0]};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Words j >= thr must already be streaming; word thr-1 must not yet be visible.
  task automatic send_burst(input logic [DW-2:0] base, input int n, input int thr);
    for (int j = 0; j < n; j++) begin
      din = mk(base + 26'(j), 1'b1);
      exp_q.push_back(base + 26'(j));
      tick();
      if (j == thr - 1) chk("prefill_quiet", dot, '0);
      else if (j >= thr) chk("stream_valid", DW'(dot[EB]), DW'(1));
    end
    din = '0;
  endtask

  task automatic drain(input int n);
    din = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      chk("drain_valid", DW'(dot[EB]), DW'(1));
    end
    tick();
    chk("drain_end", dot, '0);
  endtask

  always @(negedge CLK) begin
    logic [DW-2:0] e;
    if (dot[EB]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got %h expected no output at %0t", dot, $time);
      end else begin
        e = exp_q.pop_front();
        if (pay(dot) !== e) begin
          errors++;
          $display("FAIL payload: got %h expected %h at %0t", pay(dot), e, $time);
        end
      end
    end
  end

  initial begin
    #1 RST_X = 1'b1;
    EN = 1'b1;
    for (int i = 0; i < 50; i++) begin
      din = mk(26'(i * 3), i[0]);
      tick();
      chk("reset_hold", dot, '0);
    end
    RST_X = 1'b0;
    din   = '0;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("post_reset", dot, '0);
    end

    send_burst(26'd0, 100, 11);
    drain(11);
    chk("stream_sb_empty", DW'(exp_q.size()), '0);

    send_burst(26'h100, 5, 11);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("below_thr", dot, '0);
    end
    send_burst(26'h105, 6, 6);
    drain(11);

    send_burst(26'h2000000, 20, 11);
    drain(11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_idle", dot, '0);
    end
    send_burst(26'h2ABCDE0, 20, 11);
    drain(11);

    send_burst(26'h300, 20, 11);
    CLR = 1'b1;
    din = mk(26'h3FF, 1'b1);
    tick();
    chk("clr_edge", dot, '0);
    chk("clr_discard", DW'(exp_q.size()), DW'(11));
    exp_q.delete();
    CLR = 1'b0;
    din = '0;
    send_burst(26'h400, 15, 11);
    drain(11);

    send_burst(26'h500, 15, 11);
    EN  = 1'b0;
    din = mk(26'h5FF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_low", dot, '0);
    end
    EN = 1'b1;
    drain(11);

    tick();
    chk("final_sb_empty", DW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
